// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes: BYTES_PER_CYCLE computed inverse S-boxes walk the 128-bit state.
// Define INV_SUB_BYTES_FUSE_SHIFT_EN to fold InvShiftRows into the capture of istate.
module inv_sub_bytes_seq #(
   parameter int unsigned BYTES_PER_CYCLE = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] istate,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ostate
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [4:0] STEP = 5'(BYTES_PER_CYCLE);

   generate
      if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
          BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bpc
         $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse and maps 0 to 0 without a special case.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] x2, x3, x12, x15, x240;
      x2   = gf_mul(x, x);
      x3   = gf_mul(x2, x);
      x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
      x15  = gf_mul(x12, x3);
      x240 = gf_mul(x15, x15);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      return gf_mul(gf_mul(x240, x12), x2);
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      logic [7:0] a;
      a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      return gf_inv(a);
   endfunction

`ifdef INV_SUB_BYTES_FUSE_SHIFT_EN
   // Byte k sits at row 3-(k%4), column k/4; each row r rotates right by r columns.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      int r, c, src;
      o = '0;
      for (int k = 0; k < 16; k++) begin
         r   = 3 - (k % 4);
         c   = k / 4;
         src = 4 * ((c - r + 4) % 4) + (3 - r);
         o[8*k +: 8] = s[8*src +: 8];
      end
      return o;
   endfunction
`endif

   logic [1:0]   st_q, st_d;
   logic [4:0]   idx_q, idx_d;
   logic [127:0] state_q, state_d;
   logic [127:0] cap;
   logic [3:0]   pos;

`ifdef INV_SUB_BYTES_FUSE_SHIFT_EN
   assign cap = inv_shift_rows(istate);
`else
   assign cap = istate;
`endif

   always_comb begin
      st_d    = st_q;
      idx_d   = idx_q;
      state_d = state_q;
      pos     = 4'd0;
      case (st_q)
         IDLE: begin
            if (in_valid) begin
               st_d    = BUSY;
               idx_d   = 5'd0;
               state_d = cap;
            end
         end
         BUSY: begin
            for (int g = 0; g < int'(BYTES_PER_CYCLE); g++) begin
               pos = idx_q[3:0] + 4'(g);
               state_d[{pos, 3'b000} +: 8] = inv_sbox(state_q[{pos, 3'b000} +: 8]);
            end
            idx_d = idx_q + STEP;
            if (idx_q + STEP == 5'd16) st_d = DONE;
         end
         DONE: begin
            if (out_ready) st_d = IDLE;
         end
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q    <= IDLE;
         idx_q   <= 5'd0;
         state_q <= '0;
      end else begin
         st_q    <= st_d;
         idx_q   <= idx_d;
         state_q <= state_d;
      end
   end

   assign in_ready  = (st_q == IDLE);
   assign out_valid = (st_q == DONE);
   assign ostate    = state_q;

endmodule

// File: doc/inv_sub_bytes_seq.md
# inv_sub_bytes_seq

Iterative InvSubBytes stage for the AES-128 decryption datapath. It sits directly downstream of the combinational InvShiftRows stage and consumes that stage's 128-bit state. It substitutes every byte through the inverse S-box, processing BYTES_PER_CYCLE bytes per clock, and hands the result to the AddRoundKey stage over a valid/ready handshake. Trading latency for a small number of inverse S-box instances keeps area low enough for the SPI-attached core.

## Interface
- BYTES_PER_CYCLE, 4: inverse S-box instances. Legal values are 1, 2, 4, 8 and 16; any other value is a elaboration error.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  istate is valid.
- in_ready  output  1  block can accept a state.
- istate  input  128  input state. Byte k occupies istate[8k+:8]; its row is 3-(k mod 4) and its column is k/4.
- out_valid  output  1  ostate holds a finished result.
- out_ready  input  1  downstream accepts ostate.
- ostate  output  128  substituted state, using the same byte layout as istate.

## Operation
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE→BUSY on in_valid && in_ready. On that edge: istate is captured into the working register, and byte counter idx is cleared to 0.
- BUSY, each cycle: bytes idx .. idx+BYTES_PER_CYCLE-1 are replaced in place by InvSbox(byte), then idx += BYTES_PER_CYCLE. Bytes are processed in ascending order of k.
- BUSY→DONE on the edge that processes the final group (idx+BYTES_PER_CYCLE == 16).
- DONE→IDLE on out_ready. While out_ready is low, ostate and out_valid stay stable.
- InvSbox(x) is the inverse affine transform (rotations by 1, 3 and 6, XOR 0x05) followed by multiplicative inverse in GF(2^8) modulo 0x11B, with inverse(0)=0. It is computed, not tabulated.
- idx is 5 bits wide. It never exceeds 16 and never wraps.
- in_valid outside IDLE is ignored; istate is not sampled.
- ostate is driven from the working register at all times. It is only meaningful while out_valid=1.
- Reset asserted mid-BUSY or in DONE aborts the block: state→IDLE, and partial results are discarded.

## Timing
- Reset values: FSM state=IDLE, in_ready=1, out_valid=0, ostate=128'h0, idx=0.
- Latency: accept on edge N, out_valid=1 after edge N+16/BYTES_PER_CYCLE. With the default value this is N+4.
- Throughput: the earliest next accept is the cycle after the out_ready handshake. The minimum period is 16/BYTES_PER_CYCLE+2 cycles.
- in_ready and out_valid are decoded purely from FSM state, with no combinational path from inputs.
- A same-cycle out_ready and in_valid in DONE completes only the output handshake. The new input is accepted one cycle later, in IDLE.

## Configuration
- INV_SUB_BYTES_FUSE_SHIFT_EN, when defined: InvShiftRows is applied to istate at capture time. The captured state is:
  - output byte (row r, column c) = input byte (row r, column (c-r) mod 4).
  - Result: ostate = InvSubBytes(InvShiftRows(istate)), so the upstream InvShiftRows stage can be removed.
  - Latency is unchanged.
- Undefined: istate is captured unmodified, and ostate = InvSubBytes(istate).

## Test plan
- Reset mid-BUSY: load 128'h63…63, then assert reset 2 cycles after accept → immediately in_ready=1, out_valid=0, ostate=0. A fresh load afterwards completes normally.
- Constant vectors, default parameter: istate=128'h63636363…63 → ostate=128'h0 with out_valid exactly 4 cycles after accept. istate=128'h0 → ostate=128'h5252…52.
- Per-byte mapping: istate bytes 0x7C, 0x16 and 0xFF alternating → output bytes 0x01, 0xFF and 0x7D respectively. Sweep all 256 byte values across 16 loads and check each against a reference inverse S-box.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → ostate and out_valid stable, in_ready=0, and in_valid pulses are ignored. Then out_ready=1 → IDLE the next cycle.
- Parameter sweep: BYTES_PER_CYCLE=1 gives latency 16, and BYTES_PER_CYCLE=16 gives latency 1. Both produce results identical to the default for the same input.
- With INV_SUB_BYTES_FUSE_SHIFT_EN: istate with byte k = k → ostate byte k = InvSbox(src(k)), per the InvShiftRows mapping. For example, output byte 0 = InvSbox(0x04) and output byte 15 = InvSbox(0x0F).
